// File: rtl/bram_dma_if.sv
// Signal bundle between the block-copy DMA (master) and its sequencer/RAM side (slave).
// The checksum output exists only when BRAM_DMA_CHECKSUM_EN is defined.
interface bram_dma_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic          start;
   logic [AW-1:0] src;
   logic [AW-1:0] dst;
   logic [AW-1:0] len;
   logic          busy;
   logic          done;
   logic [AW-1:0] mem_address;
   logic          mem_wren_n;
   logic          mem_oen_n;
   logic [DW-1:0] mem_data_out;
   logic [DW-1:0] mem_data_in;
`ifdef BRAM_DMA_CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   modport master (
      input  start, src, dst, len, mem_data_in,
`ifdef BRAM_DMA_CHECKSUM_EN
      output checksum,
`endif
      output busy, done, mem_address, mem_wren_n, mem_oen_n, mem_data_out
   );

   modport slave (
      output start, src, dst, len, mem_data_in,
`ifdef BRAM_DMA_CHECKSUM_EN
      input  checksum,
`endif
      input  busy, done, mem_address, mem_wren_n, mem_oen_n, mem_data_out
   );
endinterface

// File: rtl/bram_dma.sv
// Forward block copy within one single-port RAM, two cycles per word (read, then write).
// Optional running sum of written words enabled by BRAM_DMA_CHECKSUM_EN.
module bram_dma #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   bram_dma_if.master bus
);
   localparam logic [1:0]    ST_IDLE = 2'd0;
   localparam logic [1:0]    ST_RD   = 2'd1;
   localparam logic [1:0]    ST_WR   = 2'd2;
   localparam logic [1:0]    ST_DONE = 2'd3;
   localparam logic [AW-1:0] ONE_A   = AW'(1);

   logic [1:0]    state_r;
   logic [AW-1:0] cur_src_r;
   logic [AW-1:0] cur_dst_r;
   logic [AW-1:0] remaining_r;

   logic [AW-1:0] mem_address_s;
   logic          mem_wren_n_s;
   logic          mem_oen_n_s;
   logic [DW-1:0] mem_data_out_s;
   logic          busy_s;
   logic          done_s;

   // Job sequencing: capture on accepted start, step addresses on each write edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cur_src_r   <= '0;
         cur_dst_r   <= '0;
         remaining_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  if (bus.len != '0) begin
                     cur_src_r   <= bus.src;
                     cur_dst_r   <= bus.dst;
                     remaining_r <= bus.len;
                     state_r     <= ST_RD;
                  end else begin
                     state_r     <= ST_DONE;
                  end
               end
            end
            ST_RD: begin
               state_r <= ST_WR;
            end
            ST_WR: begin
               cur_src_r   <= cur_src_r + ONE_A;
               cur_dst_r   <= cur_dst_r + ONE_A;
               remaining_r <= remaining_r - ONE_A;
               state_r     <= (remaining_r == ONE_A) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef BRAM_DMA_CHECKSUM_EN
   logic [DW-1:0] checksum_r;

   function automatic logic [DW-1:0] csum_add(input logic [DW-1:0] acc, input logic [DW-1:0] word);
      return acc + word;
   endfunction

   // Running sum of written words, cleared by every accepted start (including len=0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum_r <= '0;
      end else if (state_r == ST_IDLE && bus.start) begin
         checksum_r <= '0;
      end else if (state_r == ST_WR) begin
         checksum_r <= csum_add(checksum_r, bus.mem_data_in);
      end
   end

   assign bus.checksum = checksum_r;
`endif

   // Memory strobes decoded from state, so reset deasserts them without waiting for a clock.
   always_comb begin
      mem_address_s  = '0;
      mem_wren_n_s   = 1'b1;
      mem_oen_n_s    = 1'b1;
      mem_data_out_s = '0;
      busy_s         = 1'b0;
      done_s         = 1'b0;
      case (state_r)
         ST_RD: begin
            mem_address_s = cur_src_r;
            mem_oen_n_s   = 1'b0;
            busy_s        = 1'b1;
         end
         ST_WR: begin
            mem_address_s  = cur_dst_r;
            mem_wren_n_s   = 1'b0;
            mem_data_out_s = bus.mem_data_in;
            busy_s         = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
         end
         default: begin
            done_s = 1'b0;
         end
      endcase
   end

   assign bus.mem_address  = mem_address_s;
   assign bus.mem_wren_n   = mem_wren_n_s;
   assign bus.mem_oen_n    = mem_oen_n_s;
   assign bus.mem_data_out = mem_data_out_s;
   assign bus.busy         = busy_s;
   assign bus.done         = done_s;
endmodule

// File: tb/tb_bram_dma.sv
// Directed bench for bram_dma: behavioural RAM, write scoreboard, timing and reset checks.
module tb_bram_dma;
   localparam int AW = 16;
   localparam int DW = 16;

   typedef struct {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   wr_t  exp_q[$];

   logic [15:0] ram [0:65535];
   logic [15:0] rdata = 16'h0000;

   always #5 clk = ~clk;

   bram_dma_if #(.AW(AW), .DW(DW)) bus ();
   bram_dma #(.AW(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   assign bus.mem_data_in = rdata;

   // Single-port RAM with registered read data.
   always @(posedge clk) begin
      if (!bus.mem_oen_n) rdata <= ram[bus.mem_address];
      if (!bus.mem_wren_n) ram[bus.mem_address] = bus.mem_data_out;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every write the DUT issues must match the next scoreboard entry.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("enables_exclusive", 32'(!bus.mem_wren_n && !bus.mem_oen_n), 32'd0);
         if (!bus.mem_wren_n) begin
            chk("wr_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               wr_t e;
               e = exp_q.pop_front();
               chk("wr_addr", 32'(bus.mem_address), 32'(e.a));
               chk("wr_data", 32'(bus.mem_data_out), 32'(e.d));
            end
         end
      end
   end

   // Reference forward copy against the current RAM image; returns the word sum.
   function automatic logic [15:0] plan(input logic [15:0] s, input logic [15:0] d, input int n);
      logic [15:0] shadow [logic [15:0]];
      logic [15:0] sum = 16'h0000;
      logic [15:0] a;
      logic [15:0] v;
      for (int i = 0; i < n; i++) begin
         a = s + 16'(i);
         v = shadow.exists(a) ? shadow[a] : ram[a];
         shadow[d + 16'(i)] = v;
         exp_q.push_back('{d + 16'(i), v});
         sum += v;
      end
      return sum;
   endfunction

   task automatic run_job(input string tag, input logic [15:0] s, input logic [15:0] d,
                          input logic [15:0] n, input int restart_at);
      logic [15:0] sum;
      int nn;
      int busy_c = 0;
      int done_c = 0;
      int rd_c = 0;
      int wr_c = 0;
      int first_done = 0;
      nn = int'(n);
      sum = plan(s, d, nn);
      @(negedge clk);
      bus.start = 1'b1; bus.src = s; bus.dst = d; bus.len = n;
      for (int k = 1; k <= 2 * nn + 4; k++) begin
         @(negedge clk);
         if (k == restart_at) begin
            bus.start = 1'b1; bus.src = s + 16'h0040; bus.dst = d + 16'h0080; bus.len = 16'd2;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.busy) busy_c++;
         if (!bus.mem_oen_n) rd_c++;
         if (!bus.mem_wren_n) wr_c++;
         if (bus.done) begin
            done_c++;
            if (first_done == 0) first_done = k;
         end
      end
      bus.start = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(busy_c), 32'(2 * nn));
      chk({tag, "_done_count"}, 32'(done_c), 32'd1);
      chk({tag, "_done_cycle"}, 32'(first_done), 32'(2 * nn + 1));
      chk({tag, "_reads"}, 32'(rd_c), 32'(nn));
      chk({tag, "_writes"}, 32'(wr_c), 32'(nn));
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
`ifdef BRAM_DMA_CHECKSUM_EN
      chk({tag, "_checksum"}, 32'(bus.checksum), 32'(sum));
`endif
   endtask

   initial begin
      logic [15:0] t1 [4];
      int done_c;
      t1[0] = 16'h1111; t1[1] = 16'h2222; t1[2] = 16'h3333; t1[3] = 16'h4444;
      for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
      bus.start = 1'b0; bus.src = 16'h0000; bus.dst = 16'h0000; bus.len = 16'h0000;

      #12;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_wren_n", 32'(bus.mem_wren_n), 32'd1);
      chk("rst_oen_n", 32'(bus.mem_oen_n), 32'd1);
      chk("rst_addr", 32'(bus.mem_address), 32'd0);
      chk("rst_wdata", 32'(bus.mem_data_out), 32'd0);
`ifdef BRAM_DMA_CHECKSUM_EN
      chk("rst_checksum", 32'(bus.checksum), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // Basic 4-word copy
      for (int i = 0; i < 4; i++) ram[16'h0010 + 16'(i)] = t1[i];
      run_job("t1", 16'h0010, 16'h0100, 16'd4, 0);
      for (int i = 0; i < 4; i++) chk("t1_ram", 32'(ram[16'h0100 + 16'(i)]), 32'(t1[i]));
`ifdef BRAM_DMA_CHECKSUM_EN
      chk("t1_checksum_const", 32'(bus.checksum), 32'h0000AAAA);
`endif

      // Zero-length job
      ram[16'h0001] = 16'h5A5A;
      run_job("t2", 16'h0000, 16'h0001, 16'd0, 0);
      chk("t2_ram_untouched", 32'(ram[16'h0001]), 32'h00005A5A);

      // Source address wrap
      ram[16'hFFFE] = 16'h000A; ram[16'hFFFF] = 16'h000B; ram[16'h0000] = 16'h000C;
      run_job("t3", 16'hFFFE, 16'h0200, 16'd3, 0);
      chk("t3_ram0", 32'(ram[16'h0200]), 32'h0000000A);
      chk("t3_ram1", 32'(ram[16'h0201]), 32'h0000000B);
      chk("t3_ram2", 32'(ram[16'h0202]), 32'h0000000C);

      // Overlapping forward copy propagates the first word
      ram[16'h0020] = 16'h0005;
      run_job("t4", 16'h0020, 16'h0021, 16'd3, 0);
      for (int i = 1; i < 4; i++) chk("t4_ram", 32'(ram[16'h0020 + 16'(i)]), 32'h00000005);

      // Start during a busy job is ignored
      for (int i = 0; i < 4; i++) ram[16'h0700 + 16'(i)] = 16'h7000 + 16'(i);
      ram[16'h0880] = 16'hBEEF;
      run_job("t5", 16'h0700, 16'h0800, 16'd4, 3);
      chk("t5_no_second_job", 32'(ram[16'h0880]), 32'h0000BEEF);

      // Reset asserted in the write cycle of word 2
      for (int i = 0; i < 4; i++) ram[16'h0400 + 16'(i)] = 16'h0A10 + 16'(i);
      ram[16'h0501] = 16'hDEAD;
      void'(plan(16'h0400, 16'h0500, 1));
      @(negedge clk);
      bus.start = 1'b1; bus.src = 16'h0400; bus.dst = 16'h0500; bus.len = 16'd4;
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk); @(posedge clk); @(posedge clk);
      #2;
      chk("t6_pre_wren_n", 32'(bus.mem_wren_n), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("t6_wren_n", 32'(bus.mem_wren_n), 32'd1);
      chk("t6_oen_n", 32'(bus.mem_oen_n), 32'd1);
      chk("t6_busy", 32'(bus.busy), 32'd0);
      chk("t6_addr", 32'(bus.mem_address), 32'd0);
      done_c = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.done) done_c++;
      end
      chk("t6_no_done", 32'(done_c), 32'd0);
      chk("t6_word1", 32'(ram[16'h0500]), 32'h00000A10);
      chk("t6_word2_unwritten", 32'(ram[16'h0501]), 32'h0000DEAD);
      chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b1;
      run_job("t6b", 16'h0400, 16'h0600, 16'd4, 0);
      for (int i = 0; i < 4; i++) chk("t6b_ram", 32'(ram[16'h0600 + 16'(i)]), 32'h00000A10 + 32'(i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
